lsu_mem_master: RTL
===================

# lsu_mem_master

Load/store initiator that sits between the core's memory stage and the word-addressed data RAM. It accepts one byte, halfword or word request at a time and drives the RAM's word-only port (write enable, address, write data, combinational read data). Sub-word stores become read-modify-write sequences, and loads return lane-extracted, sign- or zero-extended data. Misaligned accesses are flagged without touching memory.

## Interface
- No parameters. Data and address width is fixed at 32. The RAM word address is `mem_addr[31:2]`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid. Sampled only when `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- `unsigned_ld`  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `ready`  out  1  block idle and able to accept a request.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load data. Valid while `done`=1, held until the next `done`.
- `err`  out  1  misaligned or illegal request. Valid with `done`.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  32  RAM address, always word-aligned ([1:0]=00).
- `mem_wdata`  out  32  RAM write word.
- `mem_rdata`  in  32  RAM read word, combinational from `mem_addr`.

## Operation
- States: IDLE, ACCESS, WRITE, RESP. Reset forces IDLE.
- `ready` = (state==IDLE) & ~rst.
- **Accept (IDLE):** when `req` & `ready`, latch `we`, `size`, `unsigned_ld`, `addr` and `wdata`.
  - Illegal requests go IDLE→RESP with `err`=1 and no memory access. Illegal means: `size`=11; halfword with `addr[0]`=1; word with `addr[1:0]`≠00.
  - All other requests go IDLE→ACCESS.
- **ACCESS:** `mem_addr` = {latched `addr[31:2]`, 00}.
  - Load: capture the extracted and extended lane into `rdata`, then go to RESP.
  - Word store: `mem_we`=1, `mem_wdata`=latched `wdata`, then go to RESP.
  - Sub-word store: `mem_we`=0. Capture `mem_rdata` merged with the new lane into a merge register, then go to WRITE.
- **WRITE:** `mem_we`=1, same `mem_addr`, `mem_wdata`=merge register. Then go to RESP.
- **RESP:** `done`=1 and `err` reflects the request. Then go to IDLE.
- **Lanes (little-endian):**
  - Byte k=`addr[1:0]` occupies bits [8k+7:8k].
  - Halfword h=`addr[1]` occupies bits [16h+15:16h].
  - Merge replaces only the addressed lane; all other bits come from `mem_rdata`.
- **Extension:** loads replicate the lane MSB into the upper bits, or fill zeros if `unsigned_ld`. Word loads pass through unchanged. On an error, `rdata`=0.
- **Idle memory outputs:** outside ACCESS/WRITE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Busy behaviour:** `req` while `ready`=0 is ignored, not queued. The requester holds or reissues.
- **Memory port timing:** `mem_we` is decoded from registered state only and never combinationally from `req`.

## Timing
- Reset values: state IDLE, `done`=0, `err`=0, `rdata`=0, merge register 0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. `ready`=1 once `rst` deasserts.
- With the request accepted at edge T:
  - Load / word store: ACCESS in T..T+1, `done` in T+1..T+2. Latency 2 cycles.
  - Sub-word store: ACCESS, WRITE, then RESP. `done` one cycle later, latency 3 cycles.
  - Error: `done` the cycle after accept, latency 1 cycle.
- `ready` rises the cycle after `done`. Back-to-back throughput: one request per 3 cycles (load or word store) or 4 cycles (sub-word store).
- Reset mid-operation: state returns to IDLE immediately and asynchronously. `mem_we` drops in the same cycle, so a partial RMW never writes. Pending `done` is lost.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → exactly one `mem_we` pulse with `mem_addr`=0x10; load returns `rdata`=0xDEADBEEF; `done` 2 cycles after each accept.
- Word 0x11223344 @0x20, then byte store 0xAA @0x22 → RAM word 0x11AA3344; exactly one read cycle then one write cycle; `done` 3 cycles after accept.
- RAM word 0x80F07F01 @0x0, loads:
  - signed byte @0x3 → 0xFFFFFF80
  - unsigned byte @0x3 → 0x00000080
  - signed halfword @0x0 → 0x00007F01
  - signed halfword @0x2 → 0xFFFF80F0
- Halfword load @0x5 and word store @0x6 → `err`=1 and `rdata`=0 one cycle after accept; `mem_we` never asserts; RAM unchanged.
- `rst` pulse during WRITE of a byte store → `mem_we` low in the same cycle, RAM word unchanged, outputs at reset values.
- `req` held high with differing addresses while busy → only the first request is performed; the second is accepted only after `ready` returns.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for a word-only RAM.
// Sub-word stores are done as read-modify-write. Loads return the addressed
// lane sign- or zero-extended. Misaligned or illegal-size requests complete
// with err=1 and never touch the RAM.
module lsu_mem_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state;
    state_t      next_state;

    // Request fields latched at accept time; the requester may change its
    // inputs freely once the request is taken.
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        err_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        illegal;
    logic [31:0] word_addr;

    // Misalignment / illegal-size check on the incoming request.
    function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: res = {{24{lane_b[7] & ~uns}}, lane_b};
            SZ_HALF: res = {{16{lane_h[15] & ~uns}}, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of the old RAM word with new store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off);
        logic [31:0] res;
        res = old_word;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    default: res[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) res[31:16] = data[15:0];
                else        res[15:0]  = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    assign ready     = (state == IDLE) & ~rst;
    assign accept    = req & ready;
    assign illegal   = is_illegal(size, addr[1:0]);
    assign word_addr = {lat_addr[31:2], 2'b00};

    // State register; reset returns to IDLE at once so mem_we drops mid-RMW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and RAM port drive, all from registered state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        next_state = state;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr = word_addr;
                if (lat_we && lat_size == SZ_WORD) begin
                    mem_we     = 1'b1;
                    mem_wdata  = lat_wdata;
                    next_state = RESP;
                end else if (lat_we) begin
                    next_state = WRITE;
                end else begin
                    next_state = RESP;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                mem_addr   = word_addr;
                mem_wdata  = merge_q;
                next_state = RESP;
            end
            RESP: begin
                done       = 1'b1;
                err        = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, load-result capture and RMW merge register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            lat_we       <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            err_q        <= 1'b0;
            rdata        <= 32'h0;
            merge_q      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we       <= we;
                        lat_size     <= size;
                        lat_unsigned <= unsigned_ld;
                        lat_addr     <= addr;
                        lat_wdata    <= wdata;
                        err_q        <= illegal;
                        if (illegal) rdata <= 32'h0;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        rdata <= extract_lane(mem_rdata, lat_size, lat_addr[1:0], lat_unsigned);
                    end else if (lat_size != SZ_WORD) begin
                        merge_q <= merge_lane(mem_rdata, lat_wdata, lat_size, lat_addr[1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
